// File: rtl/d_ff_pipe_pkg.sv
// Shared constants and helpers for the d_ff_pipe delay line.
package d_ff_pkg;

  localparam logic [63:0] D_FF_DEFAULT_RESET = 64'h0;

  function automatic int clog2_occ(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_pipe_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module d_ff_pipe_stage #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;

  // Stage update, priority reset > flush > en > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= RESET_VAL;
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        data_r <= RESET_VAL;
      end else begin
        data_r <= data_r;
      end
    end else if (en) begin
      data_r  <= d;
      valid_r <= d_valid;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
    end
  end

  assign q       = data_r;
  assign q_valid = valid_r;

endmodule

// File: rtl/d_ff_pipe.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid, stall, flush and
// a registered occupancy count.
module d_ff_pipe
  import d_ff_pkg::*;
#(
  parameter int               WIDTH          = 8,
  parameter int               DEPTH          = 4,
  parameter logic [WIDTH-1:0] RESET_VAL      = D_FF_DEFAULT_RESET[WIDTH-1:0],
  parameter bit               CLEAR_ON_FLUSH = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              d,
  input  logic                          d_valid,
  output logic [WIDTH-1:0]              q,
  output logic                          q_valid,
  output logic [clog2_occ(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = clog2_occ(DEPTH);

  logic [WIDTH-1:0] stage_data_s  [DEPTH];
  logic             stage_valid_s [DEPTH];
  logic [OCC_W-1:0] occ_r;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] din_s;
    logic             vin_s;

    if (gi == 0) begin : g_head
      assign din_s = d;
      assign vin_s = d_valid;
    end else begin : g_link
      assign din_s = stage_data_s[gi-1];
      assign vin_s = stage_valid_s[gi-1];
    end

    d_ff_pipe_stage #(
      .WIDTH         (WIDTH),
      .RESET_VAL     (RESET_VAL),
      .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .flush  (flush),
      .d      (din_s),
      .d_valid(vin_s),
      .q      (stage_data_s[gi]),
      .q_valid(stage_valid_s[gi])
    );
  end

  // Incremental count: one entry in from d_valid, one out from the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (en) begin
      occ_r <= occ_r + OCC_W'(d_valid) - OCC_W'(stage_valid_s[DEPTH-1]);
    end else begin
      occ_r <= occ_r;
    end
  end

  assign q         = stage_data_s[DEPTH-1];
  assign q_valid   = stage_valid_s[DEPTH-1];
  assign occupancy = occ_r;

endmodule
